x_multdiv_unit: RTL
===================

Name: x_multdiv_unit

Overview:
- Multi-cycle multiply/divide engine in the execute stage, fed directly by the decode/execute pipeline latch.
- Inputs are that latch's instruction and operand outputs.
- It detects R-type mul/div and runs a 32-iteration signed shift-add multiply or restoring divide.
- While the operation runs it stalls PC, F/D and D/X, then hands a one-cycle result, exception flag and destination to the execute/memory latch.

Parameters:
- WIDTH, 32, operand/result width.
- ITER, 32, iteration count in BUSY; must equal WIDTH.

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs/registers.
- in_ir  input  32  instruction from D/X latch.
- in_A  input  32  operand A (rs) from D/X latch.
- in_B  input  32  operand B (rt) from D/X latch.
- in_valid  input  1  D/X holds a real instruction (not a bubble).
- in_hold  input  1  downstream stall; result must be held.
- out_result  output  32  mul/div result.
- out_rd  output  5  destination register, in_ir[26:22] captured at start.
- out_exception  output  1  overflow or divide-by-zero; writeback substitutes rstatus 4 (mul) or 5 (div) into $30.
- out_ready  output  1  result valid this cycle.
- out_stall  output  1  freeze PC, F/D and D/X enables; insert a bubble into X/M.

Behaviour:
- Decode:
  - start = in_valid & in_ir[31:27]==00000 & (in_ir[6:2]==00110 mul | 00111 div).
- States and transitions:
  - IDLE → BUSY on start; this edge captures |A|, |B|, operand signs, op, rd, and sets count=0.
  - IDLE with no start → IDLE.
  - BUSY: one iteration per edge, count increments.
  - BUSY → DONE on the edge where count==ITER-1.
  - DONE: out_ready=1; stays in DONE while in_hold=1.
  - DONE → IDLE on the first edge with in_hold=0.
  - DONE never re-detects start: D/X still holds the same instruction during DONE.
- Stall:
  - out_stall = (IDLE & start) | BUSY; combinational.
  - out_stall is 0 in DONE.
- Latency:
  - Start detected in cycle t (stall high in t).
  - BUSY for cycles t+1..t+32.
  - out_ready high in cycle t+33; D/X advances at the end of t+33.
- Multiply:
  - Unsigned shift-add of magnitudes into a 64-bit accumulator; negate if signs differ.
  - out_result = low 32 bits.
  - out_exception=1 iff the 64-bit product is not the sign-extension of bit 31.
- Divide:
  - Restoring division of magnitudes, truncating toward zero.
  - Quotient negated if signs differ; remainder discarded.
  - B==0: out_result=0, out_exception=1. BUSY still runs the full 32 cycles (fixed latency).
  - 0x80000000 / -1: out_result=0x80000000, out_exception=1.
- Outputs when out_ready=0:
  - out_result=0, out_exception=0, out_rd=0.
  - They are not stale values: X/M sees zeros.
- Reset:
  - Asynchronous; any state → IDLE immediately.
  - All outputs 0 and count=0, including mid-BUSY.
  - No result is produced for an interrupted op.
- Bubbles:
  - in_valid=0 never starts an op, even if in_ir matches.
- Back-to-back mul/div:
  - The second op is decoded in the IDLE cycle after DONE, giving a new 33-cycle stall.
  - No overlap and no lost instruction.

Test Plan:
- mul A=7, B=-6 → out_stall high for 33 cycles from detect; out_ready one cycle later; out_result=0xFFFFFFD6 (-42), out_exception=0, out_rd=ir[26:22].
- mul A=0x00010000, B=0x00010000 → out_result=0, out_exception=1; mul 0x7FFFFFFF×1 → 0x7FFFFFFF, exception 0.
- div -7/2 → -3 (0xFFFFFFFD); div 7/0 → result 0, exception 1; div 0x80000000/0xFFFFFFFF → 0x80000000, exception 1.
- Assert reset at BUSY count 10 → out_stall, out_ready and outputs 0 immediately; after release with in_valid=0, stays IDLE.
- in_hold=1 for 3 cycles during DONE → out_ready and out_result stable for 4 cycles, out_stall low; exactly one result; no restart on the same in_ir.
- Back-to-back mul then div (D/X advancing after DONE) → two separate stall windows, results 42 then 5 for (6×7, 35/7); an add or a bubble with a matching ir never asserts out_stall.

Source files
------------

// File: rtl/x_multdiv_unit.sv
// Multi-cycle signed multiply / restoring divide for the execute stage.
// Stalls the front of the pipeline while iterating, then presents a one-cycle result.
module x_multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      in_ir,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_valid,
    input  logic             in_hold,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_exception,
    output logic             out_ready,
    output logic             out_stall
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg;
    logic [WIDTH-1:0]  hi_reg, lo_reg, hi_next, lo_next;
    logic [WIDTH-1:0]  a_mag_reg, b_mag_reg;
    logic              op_div_reg, neg_reg, bzero_reg;
    logic [4:0]        rd_reg;
    logic [WIDTH-1:0]  res_reg, res_final;
    logic              exc_reg, exc_final;

    logic              start;
    logic [WIDTH-1:0]  a_mag_in, b_mag_in;
    logic [WIDTH:0]    mul_sum, div_shift;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]  quot_signed;
    logic              unused_ir_bits;

    assign unused_ir_bits = ^{in_ir[21:7], in_ir[1:0]};

    always_comb begin
        start = in_valid && (in_ir[31:27] == 5'b00000) &&
                ((in_ir[6:2] == 5'b00110) || (in_ir[6:2] == 5'b00111));
        a_mag_in = in_A[WIDTH-1] ? -in_A : in_A;
        b_mag_in = in_B[WIDTH-1] ? -in_B : in_B;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (count_reg == LAST) state_next = DONE;
            DONE:    if (!in_hold) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration: hi holds the partial product / partial remainder, lo the
    // multiplier / quotient bits being shifted through.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_mag_reg} : '0);
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        hi_next   = mul_sum[WIDTH:1];
        lo_next   = {mul_sum[0], lo_reg[WIDTH-1:1]};
        if (op_div_reg) begin
            if (div_shift >= {1'b0, b_mag_reg}) begin
                hi_next = WIDTH'(div_shift - {1'b0, b_mag_reg});
                lo_next = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = div_shift[WIDTH-1:0];
                lo_next = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_signed = neg_reg ? -{hi_next, lo_next} : {hi_next, lo_next};
        quot_signed = neg_reg ? -lo_next : lo_next;
        if (!op_div_reg) begin
            res_final = prod_signed[WIDTH-1:0];
            exc_final = prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};
        end else if (bzero_reg) begin
            res_final = '0;
            exc_final = 1'b1;
        end else begin
            res_final = quot_signed;
            // A positive quotient of 2^(WIDTH-1) only arises from MIN / -1.
            exc_final = lo_next[WIDTH-1] && !neg_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            op_div_reg <= 1'b0;
            neg_reg    <= 1'b0;
            bzero_reg  <= 1'b0;
            rd_reg     <= '0;
            res_reg    <= '0;
            exc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg  <= '0;
                        hi_reg     <= '0;
                        lo_reg     <= in_ir[2] ? a_mag_in : b_mag_in;
                        a_mag_reg  <= a_mag_in;
                        b_mag_reg  <= b_mag_in;
                        op_div_reg <= in_ir[2];
                        neg_reg    <= in_A[WIDTH-1] ^ in_B[WIDTH-1];
                        bzero_reg  <= (in_B == '0);
                        rd_reg     <= in_ir[26:22];
                    end
                end
                BUSY: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        res_reg <= res_final;
                        exc_reg <= exc_final;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outside DONE the X/M latch must see zeros, not the last result.
    always_comb begin
        out_ready     = (state_reg == DONE);
        out_result    = out_ready ? res_reg : '0;
        out_exception = out_ready && exc_reg;
        out_rd        = out_ready ? rd_reg : 5'd0;
        out_stall     = !reset && (((state_reg == IDLE) && start) || (state_reg == BUSY));
    end

endmodule
